cause_collector: RTL
====================

# cause_collector

Gathers every interrupt source of the processor into the 23-bit cause vector `ca` consumed by the interrupt handling block.
- Internal causes of the current instruction pass through combinationally.
- External device events are edge-detected and held pending until serviced.
- A programmable periodic timer supplies its own cause.
- Pending bits are acknowledged by `jisr`, the jump-to-ISR pulse returned by the interrupt handling block.

## Interface
Parameters:
- `NEXT`, 16, number of external event lines; fixed at 16 so that `ca` is exactly 23 bits.
- `TW`, 32, timer counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ill`  in  1  illegal instruction in the current cycle.
- `misaf`  in  1  misaligned fetch in the current cycle.
- `misals`  in  1  misaligned load/store in the current cycle.
- `sysc`  in  1  system call in the current cycle.
- `ovf`  in  1  arithmetic overflow in the current cycle.
- `ev`  in  16  external event request levels, synchronous to `clk`.
- `tmr_load`  in  1  load the timer period.
- `tmr_value`  in  32  timer period; 0 disables the timer.
- `jisr`  in  1  ISR entry taken this cycle; acknowledges all latched bits currently visible on `ca`.
- `ca`  out  23  cause vector.
- `pending`  out  18  `{ext_pend[15:0], tmr_pend, rst_pend}`, read-only status for the SPR file.

## Operation
Cause bit map:
- `ca[0]` = `rst_pend`
- `ca[1]` = `ill`
- `ca[2]` = `misaf`
- `ca[3]` = `misals`
- `ca[4]` = `sysc`
- `ca[5]` = `ovf`
- `ca[6]` = `tmr_pend`
- `ca[22:7]` = `ext_pend[15:0]`

Internal causes (bits 1-5):
- Purely combinational, no storage.
- The instruction that raised them is repeated or aborted, so latching them is unnecessary.

Reset cause (bit 0):
- `rst_pend` is set while `rst` = 1.
- Cleared on the first edge with `rst` = 0 and `jisr` = 1.

External events (bits 22:7):
- `ev_q` is a registered copy of `ev`.
- A rising edge is `ev & ~ev_q`; it sets the matching `ext_pend` bit on the next edge.
- A level held high produces exactly one pending event.

Timer (bit 6):
- `tmr_period`, `tmr_cnt`: 32-bit registers.
- When `tmr_load` = 1: `tmr_period <= tmr_value`, `tmr_cnt <= tmr_value`, and `tmr_pend` is unaffected.
- Otherwise, if `tmr_period` != 0:
  - If `tmr_cnt` == 1: `tmr_pend` is set and `tmr_cnt <= tmr_period` (periodic reload).
  - Else `tmr_cnt` decrements.
- With `tmr_period` == 0 the counter holds and never fires.
- The counter never wraps below 1 while enabled.

Acknowledge:
- On an edge with `jisr` = 1, every latched bit (`rst_pend`, `tmr_pend`, `ext_pend`) that was 1 in that cycle is cleared.
- Set wins over clear: a new external edge or a timer expiry in the same cycle as `jisr` leaves its bit at 1.

Reset values:
- `rst_pend` = 1.
- `ev_q`, `ext_pend`, `tmr_pend`, `tmr_period`, `tmr_cnt` = 0.
- Hence `ca` = 23'h000001 plus any combinational internal causes.
- `pending` = 18'h00001.

Reset mid-operation:
- `rst` overrides every other input on that edge, including `tmr_load`, `jisr` and `ev` edges.
- An `ev` line that is high through reset produces no event after reset, because `ev_q` is loaded with 0 and then samples `ev`… an event is only produced by a 0->1 transition observed after reset. Exact rule: `ev_q` <= 0 during `rst`, and edge detection is suppressed while `rst` = 1 and on the first edge after it; the first edge after reset only samples `ev`.

## Timing
- Bits 1-5: zero latency; `ca` follows the inputs in the same cycle.
- External event: `ev` rising at edge N is seen by the block at N; `ext_pend`/`ca` go high after edge N+1 and stay high until acknowledged.
- Timer: a load of period P at edge L gives `ca[6]` high after edge L+P, then every P cycles.
- Acknowledge: `jisr` at edge A clears the bits; `ca` is low after A (one cycle).
- No handshake stall; the block never back-pressures.

## Test plan
1. Reset: hold `rst` 3 cycles, release with `jisr` = 0 -> `ca` = 23'h000001 and `pending` = 18'h00001 held; pulse `jisr` -> `ca` = 0 next cycle.
2. External edge: `ev` = 16'h0001 from cycle 10 and held -> `ca[7]` = 1 from cycle 11; `jisr` at cycle 15 -> `ca[7]` = 0 from 16 and stays 0 while `ev` stays high.
3. Timer: `tmr_load` with `tmr_value` = 5 at cycle 0 -> `ca[6]` rises at cycle 5; `jisr` at 6 -> clear, rises again at 10; load 0 -> never fires again.
4. Simultaneous events: `jisr` in the same cycle as a new `ev[15]` edge and a timer expiry -> `ca[22]` and `ca[6]` remain 1; earlier pending `ca[8]` clears.
5. Internal pass-through: drive `misals` = 1 and `sysc` = 1 for one cycle -> `ca` = 23'h000018 in that same cycle, 0 in the next.
6. Reset mid-run: with `ext_pend` = 16'hFFFF and the timer at 3, assert `rst` with `tmr_load` = 1 -> `ca` = 23'h000001, timer disabled, no event from an `ev` held high through reset.

Source files
------------

// File: rtl/cause_collector.sv
// Interrupt cause collector: merges combinational instruction faults, edge-detected
// external events, a periodic timer and the reset cause into the cause vector ca.
module cause_collector #(
  parameter int NEXT = 16,
  parameter int TW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ill,
  input  logic            misaf,
  input  logic            misals,
  input  logic            sysc,
  input  logic            ovf,
  input  logic [NEXT-1:0] ev,
  input  logic            tmr_load,
  input  logic [TW-1:0]   tmr_value,
  input  logic            jisr,
  output logic [NEXT+6:0] ca,
  output logic [NEXT+1:0] pending
);

  logic [NEXT-1:0] ev_q;
  logic [NEXT-1:0] ext_pend;
  logic [NEXT-1:0] ev_rise;
  logic            rst_q;
  logic            rst_pend;
  logic            tmr_pend;
  logic            tmr_fire;
  logic [TW-1:0]   tmr_period;
  logic [TW-1:0]   tmr_cnt;

  // rst_q masks the first edge after reset, where ev_q still holds 0 rather than ev.
  always_comb begin
    ev_rise  = rst_q ? '0 : (ev & ~ev_q);
    tmr_fire = !tmr_load && (tmr_period != '0) && (tmr_cnt == TW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      rst_pend   <= 1'b1;
      ev_q       <= '0;
      ext_pend   <= '0;
      tmr_pend   <= 1'b0;
      tmr_period <= '0;
      tmr_cnt    <= '0;
    end else begin
      rst_q    <= 1'b0;
      ev_q     <= ev;
      rst_pend <= rst_pend & ~jisr;
      // A new set in the acknowledge cycle survives the clear.
      ext_pend <= ev_rise | (ext_pend & ~{NEXT{jisr}});
      tmr_pend <= tmr_fire | (tmr_pend & ~jisr);
      if (tmr_load) begin
        tmr_period <= tmr_value;
        tmr_cnt    <= tmr_value;
      end else if (tmr_period != '0) begin
        if (tmr_cnt == TW'(1)) tmr_cnt <= tmr_period;
        else                   tmr_cnt <= tmr_cnt - TW'(1);
      end
    end
  end

  always_comb begin
    ca      = {ext_pend, tmr_pend, ovf, sysc, misals, misaf, ill, rst_pend};
    pending = {ext_pend, tmr_pend, rst_pend};
  end

endmodule
